// File: rtl/state_unpack_unit.sv
// rtl/state_unpack_unit.sv - unpacks a row-ordered AES state into ALU lane operands over one or more beats
module state_unpack_unit #(
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  MCMode,
  input  logic [31:0]           row0,
  input  logic [31:0]           row1,
  input  logic [31:0]           row2,
  input  logic [31:0]           row3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   alu_operands,
  output logic [1:0]            beat_idx,
  output logic                  last_beat
);

  localparam int BEATS = 4 / LANES;
  localparam logic [1:0] LAST_IDX = 2'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][31:0] rows_q, rows_d;
  logic            mc_q, mc_d;
  logic [1:0]      beat_q, beat_d;
  logic            last_w;
  logic            accept_w;
  logic [LANES*32-1:0] lanes_w;

  // State, captured rows/mode and beat counter; everything on the output side comes from here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q  <= '0;
      mc_q    <= 1'b0;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      mc_q    <= mc_d;
      beat_q  <= beat_d;
    end
  end

  // Handshake and next-state: capture in IDLE or on the final accepted beat, else step the beat
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    mc_d     = mc_q;
    beat_d   = beat_q;
    last_w   = (state_q == SEND) && (beat_q == LAST_IDX);
    // rst gates in_ready so upstream never sees a handshake while the unit is held in reset
    in_ready = !rst && ((state_q == IDLE) || (last_w && out_ready));
    accept_w = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          rows_d  = {row3, row2, row1, row0};
          mc_d    = MCMode;
          beat_d  = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_w) begin
            beat_d = 2'd0;
            if (accept_w) begin
              rows_d  = {row3, row2, row1, row0};
              mc_d    = MCMode;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane routing: lane k of beat b takes column (or row) n = b*LANES + k of the captured state
  always_comb begin
    lanes_w = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [1:0] n;
      n = 2'((int'(beat_q) * LANES + k) % 4);
      if (mc_q) begin
        lanes_w[32*k +: 32] = {rows_q[0][8*(3-int'(n)) +: 8],
                               rows_q[1][8*(3-int'(n)) +: 8],
                               rows_q[2][8*(3-int'(n)) +: 8],
                               rows_q[3][8*(3-int'(n)) +: 8]};
      end else begin
        lanes_w[32*k +: 32] = rows_q[n];
      end
    end
  end

  // Operands are only presented while a state is in flight; idle output is forced to zero
  always_comb begin
    out_valid    = (state_q == SEND);
    alu_operands = (state_q == SEND) ? lanes_w : '0;
    beat_idx     = beat_q;
    last_beat    = last_w;
  end

endmodule

// File: tb/tb_state_unpack_unit.sv
// tb/tb_state_unpack_unit.sv - directed self-checking bench for state_unpack_unit
module tb_state_unpack_unit;

  localparam logic [63:0] MC_B0 = 64'h0105090D_0004080C;
  localparam logic [63:0] MC_B1 = 64'h03070B0F_02060A0E;
  localparam logic [63:0] RW_B0 = 64'h04050607_00010203;
  localparam logic [63:0] RW_B1 = 64'h0C0D0E0F_08090A0B;
  localparam logic [63:0] B_B0  = 64'h14151617_10111213;
  localparam logic [63:0] B_B1  = 64'h1C1D1E1F_18191A1B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mc = 1'b0;
  logic [31:0] r0 = '0, r1 = '0, r2 = '0, r3 = '0;

  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, last_beat;
  logic [63:0] alu;
  logic [1:0] beat_idx;

  logic in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic in_ready4, out_valid4, last_beat4;
  logic [127:0] alu4;
  logic [1:0] beat_idx4;

  logic in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic in_ready1, out_valid1, last_beat1;
  logic [31:0] alu1;
  logic [1:0] beat_idx1;

  int checks = 0;
  int errors = 0;
  logic [31:0] cols [4];

  always #5 clk = ~clk;

  state_unpack_unit #(.LANES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .MCMode(mc),
    .row0(r0), .row1(r1), .row2(r2), .row3(r3), .out_valid(out_valid),
    .out_ready(out_ready), .alu_operands(alu), .beat_idx(beat_idx), .last_beat(last_beat)
  );

  state_unpack_unit #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .MCMode(mc),
    .row0(r0), .row1(r1), .row2(r2), .row3(r3), .out_valid(out_valid4),
    .out_ready(out_ready4), .alu_operands(alu4), .beat_idx(beat_idx4), .last_beat(last_beat4)
  );

  state_unpack_unit #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .MCMode(mc),
    .row0(r0), .row1(r1), .row2(r2), .row3(r3), .out_valid(out_valid1),
    .out_ready(out_ready1), .alu_operands(alu1), .beat_idx(beat_idx1), .last_beat(last_beat1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    mc = m; r0 = a; r1 = b; r2 = c; r3 = d;
  endtask

  task automatic load_a(input logic m);
    load(m, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
  endtask

  initial begin
    cols[0] = 32'h0004080C;
    cols[1] = 32'h0105090D;
    cols[2] = 32'h02060A0E;
    cols[3] = 32'h03070B0F;

    // reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu", alu, 0);
    chk("rst_beat_idx", beat_idx, 0);
    chk("rst_last_beat", last_beat, 0);
    @(negedge clk); rst = 1'b0;

    // 1: MC mode, two beats of columns
    @(negedge clk); load_a(1'b1); in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("t1_idle_in_ready", in_ready, 1); chk("t1_idle_out_valid", out_valid, 0);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("t1_b0_valid", out_valid, 1); chk("t1_b0_idx", beat_idx, 0);
    chk("t1_b0_alu", alu, MC_B0); chk("t1_b0_last", last_beat, 0); chk("t1_b0_in_ready", in_ready, 0);
    @(negedge clk);
    #1 chk("t1_b1_idx", beat_idx, 1); chk("t1_b1_alu", alu, MC_B1);
    chk("t1_b1_last", last_beat, 1); chk("t1_b1_in_ready", in_ready, 1);
    @(negedge clk);
    #1 chk("t1_idle_valid", out_valid, 0); chk("t1_idle_idx", beat_idx, 0);

    // 2: row mode pass-through
    @(negedge clk); load_a(1'b0); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #1 chk("t2_b0_alu", alu, RW_B0);
    @(negedge clk);
    #1 chk("t2_b1_alu", alu, RW_B1); chk("t2_b1_last", last_beat, 1);
    @(negedge clk);
    #1 chk("t2_idle_valid", out_valid, 0);

    // 3: backpressure on beat 0
    @(negedge clk); load_a(1'b1); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_hold_alu", alu, MC_B0); chk("t3_hold_idx", beat_idx, 0);
      chk("t3_hold_in_ready", in_ready, 0); chk("t3_hold_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("t3_release_in_ready", in_ready, 0);
    @(negedge clk);
    #1 chk("t3_b1_idx", beat_idx, 1); chk("t3_b1_alu", alu, MC_B1);
    @(negedge clk);
    #1 chk("t3_idle_valid", out_valid, 0);

    // 4: back-to-back; next state offered early is held off until the last beat, MCMode change ignored
    @(negedge clk); load_a(1'b1); in_valid = 1'b1;
    @(negedge clk); load(1'b0, 32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F);
    #1 chk("t4_b0_in_ready", in_ready, 0); chk("t4_b0_alu", alu, MC_B0);
    @(negedge clk);
    #1 chk("t4_b1_alu", alu, MC_B1); chk("t4_b1_in_ready", in_ready, 1); chk("t4_b1_valid", out_valid, 1);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("t4_n0_valid", out_valid, 1); chk("t4_n0_idx", beat_idx, 0); chk("t4_n0_alu", alu, B_B0);
    @(negedge clk);
    #1 chk("t4_n1_alu", alu, B_B1); chk("t4_n1_last", last_beat, 1);
    @(negedge clk);
    #1 chk("t4_idle_valid", out_valid, 0);

    // 5: asynchronous reset mid-state
    @(negedge clk); load_a(1'b1); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b0;
    #1 chk("t5_pre_idx", beat_idx, 1);
    #1 rst = 1'b1;
    #1 chk("t5_rst_valid", out_valid, 0); chk("t5_rst_alu", alu, 0);
    chk("t5_rst_idx", beat_idx, 0); chk("t5_rst_in_ready", in_ready, 0); chk("t5_rst_last", last_beat, 0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; load_a(1'b0); in_valid = 1'b1;
    #1 chk("t5_post_in_ready", in_ready, 1); chk("t5_post_valid", out_valid, 0);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("t5_first_idx", beat_idx, 0); chk("t5_first_alu", alu, RW_B0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("t5_idle_valid", out_valid, 0);

    // 6a: four lanes, single beat
    @(negedge clk); load_a(1'b1); in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(negedge clk); in_valid4 = 1'b0;
    #1 chk("t6_l4_alu", alu4, 128'h03070B0F_02060A0E_0105090D_0004080C);
    chk("t6_l4_last", last_beat4, 1); chk("t6_l4_idx", beat_idx4, 0);
    chk("t6_l4_valid", out_valid4, 1); chk("t6_l4_in_ready", in_ready4, 1);
    @(negedge clk);
    #1 chk("t6_l4_idle", out_valid4, 0);

    // 6b: one lane, four beats
    @(negedge clk); in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(negedge clk); in_valid1 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1 chk("t6_l1_alu", alu1, cols[b]); chk("t6_l1_idx", beat_idx1, b[1:0]);
      chk("t6_l1_last", last_beat1, (b == 3) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    #1 chk("t6_l1_idle", out_valid1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
